// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: hits answer in 1 cycle, misses refill the whole line in order.
// Memory side uses a level enable held until a one-cycle valid; CPU holds cpu_enable until cpu_valid.
module icache_direct #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_enable,
  input  logic [31:0] cpu_addr,
  output logic        cpu_valid,
  output logic [31:0] cpu_data,
  input  logic        flush,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF_BITS = $clog2(WORDS);
  localparam int IDX_BITS = $clog2(LINES);
  localparam int IDX_LSB  = 2 + OFF_BITS;
  localparam int TAG_LSB  = IDX_LSB + IDX_BITS;
  localparam int TAG_W    = 32 - TAG_LSB;
  localparam int KW       = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int DW       = IDX_BITS + OFF_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [31:0]      data_arr [LINES*WORDS];
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [LINES-1:0] line_vld;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic             flush_seen;
  logic [31:2]      fill_addr;

  logic [IDX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [KW-1:0]       req_off;
  logic [DW-1:0]       req_word;
  logic [IDX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic [KW-1:0]       fill_off;
  logic [DW-1:0]       fill_wr_word;
  logic [DW-1:0]       fill_rd_word;

  logic accept;
  logic hit;
  logic last_word;
  logic fill_done;
  logic unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  assign req_idx  = cpu_addr[TAG_LSB-1:IDX_LSB];
  assign req_tag  = cpu_addr[31:TAG_LSB];
  assign fill_idx = fill_addr[TAG_LSB-1:IDX_LSB];
  assign fill_tag = fill_addr[31:TAG_LSB];

  generate
    if (OFF_BITS > 0) begin : g_off
      assign req_off      = cpu_addr[IDX_LSB-1:2];
      assign fill_off     = fill_addr[IDX_LSB-1:2];
      assign req_word     = {req_idx, req_off};
      assign fill_wr_word = {fill_idx, k};
      assign fill_rd_word = {fill_idx, fill_off};
    end else begin : g_nooff
      assign req_off      = '0;
      assign fill_off     = '0;
      assign req_word     = req_idx;
      assign fill_wr_word = fill_idx;
      assign fill_rd_word = fill_idx;
    end
  endgenerate

  function automatic logic [31:0] line_base(input logic [31:2] a);
    return {a[31:IDX_LSB], {IDX_LSB{1'b0}}};
  endfunction

  // The cycle that presents cpu_valid never accepts: the CPU still holds the old request.
  assign accept    = (state == S_IDLE) && cpu_enable && !cpu_valid && !flush;
  assign hit       = line_vld[req_idx] && (tag_arr[req_idx] == req_tag);
  assign last_word = (k == KW'(WORDS - 1));
  assign fill_done = (state == S_FILL) && mem_valid && last_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      k          <= '0;
      flush_seen <= 1'b0;
      fill_addr  <= '0;
      line_vld   <= '0;
      cpu_valid  <= 1'b0;
      cpu_data   <= '0;
      mem_enable <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_valid <= 1'b0;
      if (flush) begin
        line_vld <= '0;
        if (state != S_IDLE) flush_seen <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            if (hit) begin
              cpu_valid <= 1'b1;
              cpu_data  <= data_arr[req_word];
              hit_count <= hit_count + 32'd1;
            end else begin
              miss_count <= miss_count + 32'd1;
              fill_addr  <= cpu_addr[31:2];
              k          <= '0;
              flush_seen <= 1'b0;
              mem_enable <= 1'b1;
              mem_addr   <= line_base(cpu_addr[31:2]);
              state      <= S_FILL;
            end
          end
        end

        S_FILL: begin
          if (mem_valid) begin
            mem_enable <= 1'b0;
            if (!last_word) begin
              k     <= k + 1'b1;
              state <= S_GAP;
            end else begin
              // A flush landing on the final beat must also keep the line invalid.
              if (!flush_seen && !flush) line_vld[fill_idx] <= 1'b1;
              cpu_valid <= 1'b1;
              cpu_data  <= (fill_off == k) ? mem_rdata : data_arr[fill_rd_word];
              k         <= '0;
              state     <= S_IDLE;
            end
          end
        end

        S_GAP: begin
          mem_enable <= 1'b1;
          mem_addr   <= line_base(fill_addr) | (32'(k) << 2);
          state      <= S_FILL;
        end

        default: begin
          mem_enable <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  // Storage arrays carry no reset; a fill aborted by rst never sets the valid bit.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_FILL) && mem_valid) begin
      data_arr[fill_wr_word] <= mem_rdata;
      if (fill_done) tag_arr[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the CPU fetch port and the memory controller's instruction port. It serves CPU fetches that hit in one cycle. On a miss it refills the whole line from the memory controller, one word at a time, using the same enable/valid handshake the memory controller already exposes. A flush input invalidates all lines after stores to code memory, and free-running hit/miss counters are provided for profiling.

## Interface
- LINES, 16: number of cache lines; power of 2, ≥2.
- WORDS, 4: 32-bit words per line; power of 2, ≥1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cpu_enable  in  1  fetch request; level, held until cpu_valid is seen.
- cpu_addr  in  32  byte address; bits [1:0] ignored; stable while cpu_enable is high.
- cpu_valid  out  1  one-cycle pulse; cpu_data is valid in that cycle.
- cpu_data  out  32  fetched instruction word.
- flush  in  1  one-cycle pulse; invalidates all lines.
- mem_enable  out  1  refill request to the memory controller instruction port.
- mem_addr  out  32  word-aligned refill address.
- mem_valid  in  1  one-cycle pulse; mem_rdata is valid.
- mem_rdata  in  32  refill data.
- hit_count  out  32  accepted hits; wraps.
- miss_count  out  32  accepted misses; wraps.

## Operation
- Address split: offset = addr[2+log2(WORDS)-1:2], index = next log2(LINES) bits, tag = remaining upper bits.
- Storage: data array LINES×WORDS×32, tag array, and one valid bit per line.
- States: IDLE, FILL, GAP.
- IDLE:
  - A request is accepted when cpu_enable=1, cpu_valid=0 and flush=0.
  - Hit (valid[index] and tag matches): cpu_valid<=1, cpu_data<=array word, hit_count++. Stay in IDLE.
  - Miss: miss_count++, latch the request address, set fill counter k=0, clear flush_seen, go to FILL.
- FILL:
  - mem_enable=1, mem_addr = {tag, index, k, 2'b00}.
  - On mem_valid: write mem_rdata into word k.
  - If k<WORDS-1: k++, go to GAP.
  - Otherwise: write the tag; set valid[index] unless flush_seen; cpu_valid<=1; cpu_data<= requested word (bypassed from mem_rdata when the requested offset equals k); go to IDLE.
- GAP: mem_enable=0 for exactly one cycle, then FILL.
- Line fill order is always word 0 through WORDS-1. There is no critical-word-first.
- mem_valid is ignored outside FILL.
- flush:
  - In IDLE: all valid bits clear at the next edge. A request in the same cycle is not accepted; it is accepted the next cycle and misses.
  - During FILL/GAP: all valid bits clear and flush_seen is set. The fill completes and the CPU is served, but the line stays invalid.
- Outputs cpu_valid, cpu_data, mem_enable and mem_addr are registered.

## Timing
- Reset values: cpu_valid=0, cpu_data=0, mem_enable=0, mem_addr=0, hit_count=0, miss_count=0, all valid bits 0, state IDLE, flush_seen=0, k=0. Data and tag arrays are not reset.
- Reset mid-refill aborts the fill. mem_enable is 0 in the cycle after the reset edge, no line is validated, and no cpu_valid is issued.
- Cycle numbering: request first sampled in cycle 0.
- Hit latency: cpu_valid in cycle 1.
- Miss latency:
  - mem_enable rises in cycle 1.
  - If memory asserts mem_valid in the L-th cycle of each enable, each word costs L+1 cycles.
  - cpu_valid is high in cycle WORDS·(L+1).
- cpu_valid is never high on two consecutive cycles. The cycle in which cpu_valid is high never accepts a new request, because the CPU drops cpu_enable one cycle after seeing valid.
- mem_enable drops the cycle after mem_valid. mem_addr is stable for as long as mem_enable is high.
- Counters increment at the acceptance edge and wrap from 0xFFFFFFFF to 0.

## Test plan
- Cold miss, WORDS=4, memory L=2, fetch 0x00000008:
  - Required: mem_addr sequence 0x0, 0x4, 0x8, 0xC, each separated by one mem_enable-low cycle.
  - Required: cpu_valid in cycle 12 with the word stored at 0x8; miss_count=1.
- Hit after the fill, fetch 0x0000000C: cpu_valid in cycle 1 with the word at 0xC, no mem_enable activity, hit_count=1.
- Conflict: fetch 0x00000100 (same index as 0x0, LINES=16, WORDS=4) → miss and refill. A following fetch of 0x0 → miss again.
- Flush in IDLE, then fetch 0x4 → miss with a refill. Flush pulsed during a GAP cycle → CPU served, and the immediate refetch of the same address misses.
- rst asserted in the second FILL cycle → mem_enable=0 next cycle, cpu_valid never pulses, and the refetch misses.
- Back-to-back CPU-style handshake: 1000 sequential fetches over an 8-line loop → every cpu_valid is a single-cycle pulse; after the first pass hit_count + miss_count = 1000 and miss_count = 8.
